// File: rtl/riscv_dram_ctrl.sv
// Line-level DRAM controller for the data-cache miss path: optional write-back,
// then optional refill, with a fixed stall before each DRAM access.
module riscv_dram_ctrl #(
  parameter int DATA_WIDTH  = 128,
  parameter int S_ADDR      = 10,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic                  req_rd,
  input  logic [S_ADDR-1:0]     req_wb_addr,
  input  logic [DATA_WIDTH-1:0] req_wb_data,
  input  logic [S_ADDR-1:0]     req_addr,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [S_ADDR-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR_WAIT, WR, RD_WAIT, RD, RD_CAP, DONE} state_t;

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  // With no stall the wait states are skipped entirely.
  localparam state_t WR_ENTRY = (WAIT_CYCLES == 0) ? WR : WR_WAIT;
  localparam state_t RD_ENTRY = (WAIT_CYCLES == 0) ? RD : RD_WAIT;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_q, wr_d, rd_q, rd_d;
  logic [S_ADDR-1:0]     wb_addr_q, wb_addr_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d, rdata_q, rdata_d;
  logic                  ready_q, rsp_q, wren_q, rden_q;
  logic [S_ADDR-1:0]     maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        wr_d      = req_wr;
        rd_d      = req_rd;
        wb_addr_d = req_wb_addr;
        wb_data_d = req_wb_data;
        addr_d    = req_addr;
        if (req_wr)      state_d = WR_ENTRY;
        else if (req_rd) state_d = RD_ENTRY;
        else             state_d = DONE;
      end
      WR_WAIT: if (cnt_q == CNT_LAST) state_d = WR; else cnt_d = cnt_q + CW'(1);
      WR:      state_d = rd_q ? RD_ENTRY : DONE;
      RD_WAIT: if (cnt_q == CNT_LAST) state_d = RD; else cnt_d = cnt_q + CW'(1);
      RD:      state_d = RD_CAP;
      RD_CAP: begin
        rdata_d = mem_rdata;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // DRAM address/data only move when a WR or RD cycle is entered.
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    if (state_d == WR) begin
      maddr_d  = wb_addr_d;
      mwdata_d = wb_data_d;
    end else if (state_d == RD) begin
      maddr_d  = addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b1;
      rsp_q     <= 1'b0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      ready_q   <= (state_d == IDLE);
      rsp_q     <= (state_d == DONE);
      wren_q    <= (state_d == WR);
      rden_q    <= (state_d == RD);
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
    end
  end

  // Enables are masked by reset so a pending WR cycle never reaches the DRAM.
  assign mem_wren  = wren_q & rst_n;
  assign mem_rden  = rden_q & rst_n;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign req_ready = ready_q;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_riscv_dram_ctrl.sv
// Directed bench: a WAIT_CYCLES=4 controller and a WAIT_CYCLES=0 controller,
// each with its own behavioural DRAM; shared request fields, separate valids.
module tb_riscv_dram_ctrl;
  localparam int DW = 128;
  localparam int AW = 10;
  localparam logic [DW-1:0] D_ROW  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] B_ROW  = 128'hCAFEF00D11223344556677889900AABB;
  localparam logic [DW-1:0] O_ROW  = 128'h30303030303030303030303030303030;
  localparam logic [DW-1:0] A5_ROW = {16{8'hA5}};
  localparam logic [DW-1:0] DB_ROW = {4{32'hDEADBEEF}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, a_valid, b_valid, r_wr, r_rd;
  logic [AW-1:0] r_wb_addr, r_addr;
  logic [DW-1:0] r_wb_data;

  logic a_ready, a_rsp, a_wren, a_rden, b_ready, b_rsp, b_wren, b_rden;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_rsp_data, a_wdata, a_rdata, b_rsp_data, b_wdata, b_rdata;

  logic [DW-1:0] mem_a [0:1023];
  logic [DW-1:0] mem_b [0:1023];
  logic pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int checks = 0;
  int errors = 0;

  riscv_dram_ctrl #(.DATA_WIDTH(DW), .S_ADDR(AW), .WAIT_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_wr(r_wr), .req_rd(r_rd), .req_wb_addr(r_wb_addr), .req_wb_data(r_wb_data),
    .req_addr(r_addr), .rsp_valid(a_rsp), .rsp_rdata(a_rsp_data),
    .mem_wren(a_wren), .mem_rden(a_rden), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_rdata(a_rdata));

  riscv_dram_ctrl #(.DATA_WIDTH(DW), .S_ADDR(AW), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_wr(r_wr), .req_rd(r_rd), .req_wb_addr(r_wb_addr), .req_wb_data(r_wb_data),
    .req_addr(r_addr), .rsp_valid(b_rsp), .rsp_rdata(b_rsp_data),
    .mem_wren(b_wren), .mem_rden(b_rden), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_rdata(b_rdata));

  // DRAM: registered read, write ignored while rden is high.
  always @(posedge clk) begin
    if (pre_we) begin
      mem_a[pre_addr] <= pre_data;
      mem_b[pre_addr] <= pre_data;
    end else begin
      if (a_wren && !a_rden) mem_a[a_addr] <= a_wdata;
      if (b_wren && !b_rden) mem_b[b_addr] <= b_wdata;
    end
    if (a_rden) a_rdata <= mem_a[a_addr];
    if (b_rden) b_rdata <= mem_b[b_addr];
  end

  task automatic preload(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = ad; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one request and records cycle numbers relative to the accept cycle (0).
  task automatic run_req(input bit sel, input logic wr, input logic rd,
                         input logic [AW-1:0] wba, input logic [DW-1:0] wbd,
                         input logic [AW-1:0] ra, output int rsp_c, output int rden_c,
                         output int wren_c, output int wren_n, output bit both);
    rsp_c = -1; rden_c = -1; wren_c = -1; wren_n = 0; both = 1'b0;
    @(negedge clk);
    r_wr = wr; r_rd = rd; r_wb_addr = wba; r_wb_data = wbd; r_addr = ra;
    if (sel) b_valid = 1'b1; else a_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      if ((sel ? b_rden : a_rden) && rden_c < 0) rden_c = k;
      if (sel ? b_wren : a_wren) begin
        wren_n++;
        if (wren_c < 0) wren_c = k;
      end
      if (sel ? (b_wren && b_rden) : (a_wren && a_rden)) both = 1'b1;
      if (sel ? b_rsp : a_rsp) begin
        rsp_c = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (a_wren !== 1'b0 || a_rden !== 1'b0) begin errors++; $display("FAIL reset_en_gate: got wren=%b rden=%b expected 0 0", a_wren, a_rden); end
    rst_n = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
    checks++; if (a_rsp !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", a_rsp); end
    checks++; if (a_addr !== '0 || a_wdata !== '0) begin errors++; $display("FAIL reset_mem_port: got addr=%0h wdata=%0h expected 0 0", a_addr, a_wdata); end
    checks++; if (a_rsp_data !== '0) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", a_rsp_data); end
    checks++; if (b_ready !== 1'b1 || b_rsp !== 1'b0) begin errors++; $display("FAIL reset_b: got ready=%b rsp=%b expected 1 0", b_ready, b_rsp); end
  endtask

  task automatic test_rd_only;
    int rc, dc, wc, wn; bit bo;
    run_req(1'b0, 1'b0, 1'b1, '0, '0, 10'h005, rc, dc, wc, wn, bo);
    checks++; if (dc !== 5) begin errors++; $display("FAIL rd_rden_cycle: got %0d expected 5", dc); end
    checks++; if (rc !== 7) begin errors++; $display("FAIL rd_rsp_cycle: got %0d expected 7", rc); end
    checks++; if (a_rsp_data !== D_ROW) begin errors++; $display("FAIL rd_data: got %0h expected %0h", a_rsp_data, D_ROW); end
    checks++; if (wn !== 0) begin errors++; $display("FAIL rd_no_write: got %0d writes expected 0", wn); end
  endtask

  task automatic test_wr_only;
    int rc, dc, wc, wn; bit bo;
    run_req(1'b0, 1'b1, 1'b0, 10'h010, A5_ROW, 10'h3FF, rc, dc, wc, wn, bo);
    checks++; if (wc !== 5) begin errors++; $display("FAIL wr_wren_cycle: got %0d expected 5", wc); end
    checks++; if (wn !== 1) begin errors++; $display("FAIL wr_wren_count: got %0d expected 1", wn); end
    checks++; if (rc !== 6) begin errors++; $display("FAIL wr_rsp_cycle: got %0d expected 6", rc); end
    checks++; if (mem_a[16] !== A5_ROW) begin errors++; $display("FAIL wr_dram_line: got %0h expected %0h", mem_a[16], A5_ROW); end
    checks++; if (a_rsp_data !== D_ROW) begin errors++; $display("FAIL wr_rdata_held: got %0h expected %0h", a_rsp_data, D_ROW); end
    checks++; if (dc !== -1) begin errors++; $display("FAIL wr_no_read: got rden at %0d expected none", dc); end
  endtask

  task automatic test_wr_rd;
    int rc, dc, wc, wn; bit bo;
    run_req(1'b0, 1'b1, 1'b1, 10'h020, DB_ROW, 10'h020, rc, dc, wc, wn, bo);
    checks++; if (wc !== 5) begin errors++; $display("FAIL wrrd_wren_cycle: got %0d expected 5", wc); end
    checks++; if (dc !== 10) begin errors++; $display("FAIL wrrd_rden_cycle: got %0d expected 10", dc); end
    checks++; if (rc !== 12) begin errors++; $display("FAIL wrrd_rsp_cycle: got %0d expected 12", rc); end
    checks++; if (a_rsp_data !== DB_ROW) begin errors++; $display("FAIL wrrd_data: got %0h expected %0h", a_rsp_data, DB_ROW); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL wrrd_exclusive: got both=%b expected 0", bo); end
  endtask

  task automatic test_zero_wait;
    int rc, dc, wc, wn; bit bo;
    run_req(1'b1, 1'b0, 1'b1, '0, '0, 10'h007, rc, dc, wc, wn, bo);
    checks++; if (dc !== 1) begin errors++; $display("FAIL w0_rden_cycle: got %0d expected 1", dc); end
    checks++; if (rc !== 3) begin errors++; $display("FAIL w0_rsp_cycle: got %0d expected 3", rc); end
    checks++; if (b_rsp_data !== B_ROW) begin errors++; $display("FAIL w0_data: got %0h expected %0h", b_rsp_data, B_ROW); end
    run_req(1'b1, 1'b0, 1'b0, 10'h001, A5_ROW, 10'h005, rc, dc, wc, wn, bo);
    checks++; if (rc !== 1) begin errors++; $display("FAIL empty_rsp_cycle: got %0d expected 1", rc); end
    checks++; if (b_rsp_data !== B_ROW || wn !== 0 || dc !== -1) begin errors++; $display("FAIL empty_side_effect: got rdata=%0h writes=%0d rden=%0d expected %0h 0 -1", b_rsp_data, wn, dc, B_ROW); end
  endtask

  task automatic test_reset_in_wr;
    @(negedge clk);
    r_wr = 1'b1; r_rd = 1'b0; r_wb_addr = 10'h030; r_wb_data = A5_ROW; r_addr = '0;
    a_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      a_valid = 1'b0;
    end
    checks++; if (a_wren !== 1'b1) begin errors++; $display("FAIL rstwr_in_wr: got wren=%b expected 1", a_wren); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_wren !== 1'b0) begin errors++; $display("FAIL rstwr_gate: got wren=%b expected 0", a_wren); end
    @(negedge clk);
    checks++; if (mem_a[48] !== O_ROW) begin errors++; $display("FAIL rstwr_dram_line: got %0h expected %0h", mem_a[48], O_ROW); end
    checks++; if (a_ready !== 1'b1 || a_rsp !== 1'b0) begin errors++; $display("FAIL rstwr_outputs: got ready=%b rsp=%b expected 1 0", a_ready, a_rsp); end
    checks++; if (a_rsp_data !== '0) begin errors++; $display("FAIL rstwr_rdata: got %0h expected 0", a_rsp_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    int rsp1 = -1, rsp2 = -1, busy_rdy = 0;
    logic rdy_after = 1'b0;
    logic [DW-1:0] d1 = '0, d2 = '0;
    @(negedge clk);
    r_wr = 1'b0; r_rd = 1'b1; r_addr = 10'h005; a_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 2) r_addr = 10'h020;
      if (rsp1 < 0 && a_ready) busy_rdy++;
      if (a_rsp && rsp1 < 0) begin
        rsp1 = k; d1 = a_rsp_data;
      end else if (rsp1 >= 0 && k == rsp1 + 1) begin
        rdy_after = a_ready;
      end else if (a_rsp) begin
        rsp2 = k; d2 = a_rsp_data;
        break;
      end
    end
    a_valid = 1'b0;
    checks++; if (busy_rdy !== 0) begin errors++; $display("FAIL b2b_busy_ready: got %0d ready cycles expected 0", busy_rdy); end
    checks++; if (rsp1 !== 7) begin errors++; $display("FAIL b2b_rsp1_cycle: got %0d expected 7", rsp1); end
    checks++; if (d1 !== D_ROW) begin errors++; $display("FAIL b2b_rsp1_data: got %0h expected %0h", d1, D_ROW); end
    checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %b expected 1", rdy_after); end
    checks++; if (rsp2 !== 15) begin errors++; $display("FAIL b2b_rsp2_cycle: got %0d expected 15", rsp2); end
    checks++; if (d2 !== DB_ROW) begin errors++; $display("FAIL b2b_rsp2_data: got %0h expected %0h", d2, DB_ROW); end
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; r_wr = 1'b0; r_rd = 1'b0;
    r_wb_addr = '0; r_wb_data = '0; r_addr = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset;
    preload(10'h005, D_ROW);
    preload(10'h007, B_ROW);
    preload(10'h030, O_ROW);
    preload(10'h020, '0);
    test_rd_only;
    test_wr_only;
    test_wr_rd;
    test_zero_wait;
    test_reset_in_wr;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
